// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one fpadd adder between NREQ requesters,
// with a per-operation watchdog that aborts when fp_done never arrives.
module fpadd_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_sum,
  output logic                 rsp_err,
  output logic                 fp_start,
  output logic [31:0]          fp_a,
  output logic [31:0]          fp_b,
  input  logic [31:0]          fp_sum,
  input  logic                 fp_done,
  output logic                 busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, gnt, winner;
  logic            found;
  int unsigned     idx;
  logic [31:0]     win_a, win_b;
  logic [TW-1:0]   timer;
  logic            timed_out;

  // Rotating priority search starting at ptr, wrapping past NREQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req_valid[PW'(idx)]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (winner == PW'(i)) begin
        win_a = req_a[32*i +: 32];
        win_b = req_b[32*i +: 32];
      end
    end
  end

  assign timed_out = (timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (fp_done || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr     <= '0;
      gnt     <= '0;
      timer   <= '0;
      fp_a    <= '0;
      fp_b    <= '0;
      rsp_sum <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          fp_a <= win_a;
          fp_b <= win_b;
          gnt  <= winner;
          ptr  <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (timer != '1) timer <= timer + 1'b1;
          // fp_done takes priority over a coincident timeout
          if (fp_done) begin
            rsp_sum <= fp_sum;
            rsp_err <= 1'b0;
          end else if (timed_out) begin
            rsp_sum <= '0;
            rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
    if (state == RESP)          rsp_valid[gnt]    = 1'b1;
    fp_start = (state == ISSUE);
    busy     = (state != IDLE);
  end

endmodule
